// File: rtl/rename_pkg.sv
// Shared defaults, index-width helpers and index typedefs for the register rename unit.
package rename_pkg;

   localparam int DEF_ARCH_REGS  = 8;
   localparam int DEF_PHYS_REGS  = 16;
   localparam int DEF_READ_PORTS = 2;

   function automatic int calc_aw(input int arch_regs);
      return $clog2(arch_regs);
   endfunction

   function automatic int calc_pw(input int phys_regs);
      return $clog2(phys_regs);
   endfunction

   typedef logic [$clog2(DEF_ARCH_REGS)-1:0] arch_idx_t;
   typedef logic [$clog2(DEF_PHYS_REGS)-1:0] phys_idx_t;

endpackage

// File: rtl/rename_free_list.sv
// Free physical register pool: bit vector, lowest-free encoder, registered population count,
// and a whole-vector reload used when speculative state is discarded.
module rename_free_list
   import rename_pkg::*;
#(
   parameter  int ARCH_REGS = DEF_ARCH_REGS,
   parameter  int PHYS_REGS = DEF_PHYS_REGS,
   localparam int PW        = calc_pw(PHYS_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_fire,
   input  logic                 release_valid,
   input  logic [PW-1:0]        release_idx,
   input  logic                 reload_valid,
   input  logic [PHYS_REGS-1:0] reload_vec,
   output logic [PW-1:0]        alloc_idx,
   output logic [PW:0]          free_count
);

   localparam int CW = PW + 1;

   logic [PHYS_REGS-1:0] free_q, free_d;
   logic [CW-1:0]        count_q, count_d;

   // Scan from the top so the last hit is the lowest set bit.
   always_comb begin
      alloc_idx = '0;
      for (int i = PHYS_REGS - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_idx = PW'(i);
      end
   end

   // The released register was not free this cycle, so it can never be the one allocated.
   always_comb begin
      free_d = free_q;
      if (alloc_fire)    free_d[alloc_idx]   = 1'b0;
      if (release_valid) free_d[release_idx] = 1'b1;
      if (reload_valid)  free_d              = reload_vec;
      count_d = '0;
      for (int i = 0; i < PHYS_REGS; i++) begin
         count_d = count_d + CW'(free_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHYS_REGS; i++) begin
            free_q[i] <= (i >= ARCH_REGS);
         end
         count_q <= CW'(PHYS_REGS - ARCH_REGS);
      end else begin
         free_q  <= free_d;
         count_q <= count_d;
      end
   end

   assign free_count = count_q;

endmodule

// File: rtl/rename_unit.sv
// Register rename: speculative and committed arch->phys maps over a shared free list,
// with combinational source lookups and single-cycle flush back to committed state.
module rename_unit
   import rename_pkg::*;
#(
   parameter  int ARCH_REGS  = DEF_ARCH_REGS,
   parameter  int PHYS_REGS  = DEF_PHYS_REGS,
   parameter  int READ_PORTS = DEF_READ_PORTS,
   localparam int AW         = calc_aw(ARCH_REGS),
   localparam int PW         = calc_pw(PHYS_REGS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [READ_PORTS-1:0]          rd_valid,
   input  logic [READ_PORTS-1:0][AW-1:0]  rd_arch,
   output logic [READ_PORTS-1:0][PW-1:0]  rd_phys,
   output logic [READ_PORTS-1:0]          rd_phys_valid,
   input  logic                           alloc_valid,
   input  logic [AW-1:0]                  alloc_arch,
   output logic                           alloc_ready,
   output logic [PW-1:0]                  alloc_phys,
   output logic [PW-1:0]                  alloc_old_phys,
   input  logic                           commit_valid,
   input  logic [AW-1:0]                  commit_arch,
   input  logic [PW-1:0]                  commit_phys,
   input  logic                           flush,
   output logic [PW:0]                    free_count
);

   if (PHYS_REGS <= ARCH_REGS) begin : g_bad_cfg
      $error("rename_unit: PHYS_REGS must exceed ARCH_REGS");
   end

   logic [PW-1:0]        spec_map_q   [ARCH_REGS];
   logic [PW-1:0]        spec_map_d   [ARCH_REGS];
   logic [PW-1:0]        commit_map_q [ARCH_REGS];
   logic [PW-1:0]        commit_map_d [ARCH_REGS];
   logic [PHYS_REGS-1:0] referenced;
   logic [PHYS_REGS-1:0] reload_vec;
   logic                 alloc_fire;

   assign alloc_ready    = (free_count != '0) && !flush;
   assign alloc_fire     = alloc_valid && alloc_ready;
   assign alloc_old_phys = spec_map_q[alloc_arch];
   assign rd_phys_valid  = rd_valid;

   for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
      assign rd_phys[g] = spec_map_q[rd_arch[g]];
   end

   always_comb begin
      commit_map_d = commit_map_q;
      if (commit_valid) commit_map_d[commit_arch] = commit_phys;
   end

   // Flush restores the committed view including this cycle's commit.
   always_comb begin
      spec_map_d = spec_map_q;
      if (alloc_fire) spec_map_d[alloc_arch] = alloc_phys;
      if (flush)      spec_map_d = commit_map_d;
   end

   always_comb begin
      referenced = '0;
      for (int a = 0; a < ARCH_REGS; a++) begin
         referenced[commit_map_d[a]] = 1'b1;
      end
      reload_vec = ~referenced;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < ARCH_REGS; a++) begin
            spec_map_q[a]   <= PW'(a);
            commit_map_q[a] <= PW'(a);
         end
      end else begin
         spec_map_q   <= spec_map_d;
         commit_map_q <= commit_map_d;
      end
   end

   rename_free_list #(
      .ARCH_REGS (ARCH_REGS),
      .PHYS_REGS (PHYS_REGS)
   ) u_free_list (
      .clk           (clk),
      .rst           (rst),
      .alloc_fire    (alloc_fire),
      .release_valid (commit_valid),
      .release_idx   (commit_map_q[commit_arch]),
      .reload_valid  (flush),
      .reload_vec    (reload_vec),
      .alloc_idx     (alloc_phys),
      .free_count    (free_count)
   );

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit at default sizes (8 arch / 16 phys / 2 read ports).
module tb_rename_unit;
   import rename_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      rd_valid;
   logic [1:0][2:0] rd_arch;
   logic [1:0][3:0] rd_phys;
   logic [1:0]      rd_phys_valid;
   logic            alloc_valid;
   logic [2:0]      alloc_arch;
   logic            alloc_ready;
   logic [3:0]      alloc_phys;
   logic [3:0]      alloc_old_phys;
   logic            commit_valid;
   logic [2:0]      commit_arch;
   logic [3:0]      commit_phys;
   logic            flush;
   logic [4:0]      free_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rename_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rd_valid       (rd_valid),
      .rd_arch        (rd_arch),
      .rd_phys        (rd_phys),
      .rd_phys_valid  (rd_phys_valid),
      .alloc_valid    (alloc_valid),
      .alloc_arch     (alloc_arch),
      .alloc_ready    (alloc_ready),
      .alloc_phys     (alloc_phys),
      .alloc_old_phys (alloc_old_phys),
      .commit_valid   (commit_valid),
      .commit_arch    (commit_arch),
      .commit_phys    (commit_phys),
      .flush          (flush),
      .free_count     (free_count)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_valid     = '0;
      rd_arch      = '0;
      alloc_valid  = 1'b0;
      alloc_arch   = '0;
      commit_valid = 1'b0;
      commit_arch  = '0;
      commit_phys  = '0;
      flush        = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic rd2(input int a0, input int a1);
      rd_valid   = 2'b11;
      rd_arch[0] = 3'(a0);
      rd_arch[1] = 3'(a1);
      #1;
   endtask

   task automatic alloc(input int arch);
      alloc_valid = 1'b1;
      alloc_arch  = 3'(arch);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic commit(input int arch, input int phys);
      commit_valid = 1'b1;
      commit_arch  = 3'(arch);
      commit_phys  = 4'(phys);
   endtask

   task automatic check_reset_state(input string tag);
      #1;
      chk({tag, "_free_count"}, int'(free_count), 8);
      chk({tag, "_alloc_ready"}, int'(alloc_ready), 1);
      chk({tag, "_alloc_phys"}, int'(alloc_phys), 8);
      for (int i = 0; i < 8; i += 2) begin
         rd2(i, i + 1);
         chk({tag, "_rd0"}, int'(rd_phys[0]), i);
         chk({tag, "_rd1"}, int'(rd_phys[1]), i + 1);
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset");
      chk("rd_valid_both", int'(rd_phys_valid), 3);
      rd_valid = 2'b01;
      #1;
      chk("rd_valid_one", int'(rd_phys_valid), 1);

      // Allocate arch1; lookup in the same cycle must still see the old mapping.
      alloc_valid = 1'b1;
      alloc_arch  = 3'd1;
      rd2(1, 0);
      chk("alloc1_phys", int'(alloc_phys), 8);
      chk("alloc1_old", int'(alloc_old_phys), 1);
      chk("alloc1_no_bypass", int'(rd_phys[0]), 1);
      tick();
      alloc_valid = 1'b0;
      rd2(1, 0);
      chk("alloc1_rd_after", int'(rd_phys[0]), 8);
      chk("alloc1_free_count", int'(free_count), 7);
      chk("alloc1_next_phys", int'(alloc_phys), 9);

      // Commit arch1/phys8 frees phys1.
      commit(1, 8);
      tick();
      idle();
      #1;
      chk("commit1_free_count", int'(free_count), 8);
      chk("commit1_next_phys", int'(alloc_phys), 1);

      // Flush restores committed map and rebuilds free list.
      do_reset();
      alloc(1);
      alloc(2);
      commit(1, 8);
      tick();
      idle();
      flush       = 1'b1;
      alloc_valid = 1'b1;
      alloc_arch  = 3'd3;
      #1;
      chk("flush_alloc_ready", int'(alloc_ready), 0);
      tick();
      idle();
      rd2(1, 2);
      chk("flush_rd_arch1", int'(rd_phys[0]), 8);
      chk("flush_rd_arch2", int'(rd_phys[1]), 2);
      chk("flush_free_count", int'(free_count), 8);
      chk("flush_next_phys", int'(alloc_phys), 1);
      rd2(3, 0);
      chk("flush_suppressed_alloc", int'(rd_phys[0]), 3);

      // Flush with a commit in the same cycle.
      do_reset();
      alloc(4);
      commit(4, 8);
      flush = 1'b1;
      tick();
      idle();
      rd2(4, 0);
      chk("flush_commit_rd4", int'(rd_phys[0]), 8);
      chk("flush_commit_free_count", int'(free_count), 8);
      chk("flush_commit_next_phys", int'(alloc_phys), 4);

      // Exhaust the free list.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         alloc_valid = 1'b1;
         alloc_arch  = 3'(i);
         #1;
         chk("fill_phys", int'(alloc_phys), 8 + i);
         tick();
      end
      alloc_arch = 3'd0;
      #1;
      chk("full_alloc_ready", int'(alloc_ready), 0);
      chk("full_free_count", int'(free_count), 0);
      tick();
      alloc_valid = 1'b0;
      rd2(0, 7);
      chk("full_9th_rd0", int'(rd_phys[0]), 8);
      chk("full_9th_rd7", int'(rd_phys[1]), 15);
      chk("full_9th_free_count", int'(free_count), 0);

      // Register released by commit is not allocatable in the same cycle.
      commit(0, 8);
      alloc_valid = 1'b1;
      alloc_arch  = 3'd5;
      #1;
      chk("release_same_cycle_ready", int'(alloc_ready), 0);
      tick();
      idle();
      rd2(5, 0);
      chk("release_free_count", int'(free_count), 1);
      chk("release_phys", int'(alloc_phys), 0);
      chk("release_ready", int'(alloc_ready), 1);
      chk("release_rd5", int'(rd_phys[0]), 13);

      // Commit and allocate in the same cycle.
      commit(1, 9);
      alloc_valid = 1'b1;
      alloc_arch  = 3'd1;
      #1;
      chk("both_alloc_phys", int'(alloc_phys), 0);
      tick();
      idle();
      rd2(1, 0);
      chk("both_free_count", int'(free_count), 1);
      chk("both_next_phys", int'(alloc_phys), 1);
      chk("both_rd1", int'(rd_phys[0]), 0);
      chk("both_rd0", int'(rd_phys[1]), 8);

      // Reset dominates everything active in the same cycle.
      rst         = 1'b1;
      alloc_valid = 1'b1;
      alloc_arch  = 3'd2;
      commit(2, 10);
      flush       = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      check_reset_state("rst_dom");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
